// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the APB register file: transfer FSM states,
//               error causes and a small index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    // Transfer sequencing: setup seen in IDLE, optional wait cycles, one
    // completing cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    // Reason a transfer completes with pslverr.
    typedef enum logic [1:0] {
        OK       = 2'd0,
        BAD_ADDR = 2'd1,
        RO_WRITE = 2'd2
    } apb_err_e;

    // Width of a register index; at least one bit even for a single register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_reg_bank.sv
// ============================================================================
// Module      : apb_reg_bank
// Description : Register storage for apb_regfile. Byte-lane masked writes,
//               combinational read mux and a flattened view of all registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W/8-1:0]          i_strb,
    output logic [DATA_W-1:0]            o_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs
);

    localparam int LANES = DATA_W / 8;

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    // Storage: update only the addressed register, only the enabled byte lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_idx == IDX_W'(i)) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (i_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux; an index past the last register reads as zero
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_rdata = r_regs[i];
            end
        end
    end

    assign o_regs = r_regs;

endmodule

`default_nettype wire

// File: rtl/apb_regfile.sv
// ============================================================================
// Module      : apb_regfile
// Description : APB slave register file with a fixed number of wait states,
//               per-register read-only mask and error response for bad
//               addresses / read-only writes. Storage lives in apb_reg_bank.
// Config      : define APB_REGFILE_PSTRB_EN to honour pstrb byte lanes;
//               otherwise every accepted write updates the whole register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_regfile #(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    output logic                         pready,
    output logic                         pslverr,
    output logic [DATA_W-1:0]            prdata,
    output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

    import apb_pkg::*;

    localparam int                LANES      = DATA_W / 8;
    localparam int                LSB        = $clog2(LANES);
    localparam int                IDX_W      = idx_width(NUM_REGS);
    localparam logic [ADDR_W-1:0] LOW_MASK   = ADDR_W'((1 << LSB) - 1);
    localparam logic [31:0]       NUM_REGS_U = 32'(NUM_REGS);
    localparam logic [3:0]        WAIT_LOAD  = 4'(WAIT_STATES);

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic [ADDR_W-1:0]   w_word;
    logic                w_aligned;
    logic                w_in_range;
    logic                w_valid;
    logic [IDX_W-1:0]    w_idx;
    logic                w_ro;
    apb_err_e            w_err;
    logic                w_we;
    logic [LANES-1:0]    w_strb;
    logic [DATA_W-1:0]   w_rdata;

    // Address decode: word index plus alignment and range qualification
    assign w_word     = paddr >> LSB;
    assign w_aligned  = (paddr & LOW_MASK) == '0;
    assign w_in_range = 32'(w_word) < NUM_REGS_U;
    assign w_valid    = w_aligned && w_in_range;
    assign w_idx      = w_word[IDX_W-1:0];

    // Read-only lookup for the addressed register
    always_comb begin
        w_ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_ro = RO_MASK[i];
            end
        end
    end

    // Error classification of the transfer currently on the bus
    always_comb begin
        w_err = OK;
        if (!w_valid) begin
            w_err = BAD_ADDR;
        end else if (pwrite && w_ro) begin
            w_err = RO_WRITE;
        end
    end

`ifdef APB_REGFILE_PSTRB_EN
    assign w_strb = pstrb;
`else
    logic w_unused_pstrb;
    assign w_unused_pstrb = ^pstrb;
    assign w_strb         = {LANES{1'b1}};
`endif

    // Write lands at the edge ending the completing cycle, only when error-free
    assign w_we = (r_state == DONE) && pwrite && (w_err == OK);

    apb_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_bank (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (pwdata),
        .i_strb  (w_strb),
        .o_rdata (w_rdata),
        .o_regs  (regs_q)
    );

    // FSM state and wait counter registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: count down access cycles, abort if the master drops psel
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_cnt_nxt   = WAIT_LOAD;
                    w_state_nxt = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end else if (penable) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Response is qualified by the registered DONE state so it is zero elsewhere
    assign pready  = (r_state == DONE);
    assign pslverr = (r_state == DONE) && (w_err != OK);
    assign prdata  = ((r_state == DONE) && !pwrite && w_valid) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile.sv
// ============================================================================
// Module      : tb_apb_regfile
// Description : Self-checking bench for apb_regfile. Three instances with
//               WAIT_STATES 0/3/2 (the first with register 0 read-only);
//               scoreboard of expected responses popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_regfile;

    localparam int ND = 3;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [ND-1:0]        preset_v;
    logic [ND-1:0]        psel_v;
    logic [ND-1:0]        penable_v;
    logic [ND-1:0]        pwrite_v;
    logic [ND-1:0][7:0]   paddr_v;
    logic [ND-1:0][31:0]  pwdata_v;
    logic [ND-1:0][3:0]   pstrb_v;
    logic [ND-1:0]        pready_v;
    logic [ND-1:0]        pslverr_v;
    logic [ND-1:0][31:0]  prdata_v;
    logic [ND-1:0][255:0] regs_v;

    apb_regfile #(.WAIT_STATES(0), .RO_MASK(8'h01)) u_dut_ws0 (
        .pclk(pclk), .preset(preset_v[0]), .psel(psel_v[0]), .penable(penable_v[0]),
        .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .prdata(prdata_v[0]), .regs_q(regs_v[0])
    );

    apb_regfile #(.WAIT_STATES(3), .RO_MASK(8'h00)) u_dut_ws3 (
        .pclk(pclk), .preset(preset_v[1]), .psel(psel_v[1]), .penable(penable_v[1]),
        .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .prdata(prdata_v[1]), .regs_q(regs_v[1])
    );

    apb_regfile #(.WAIT_STATES(2), .RO_MASK(8'h00)) u_dut_ws2 (
        .pclk(pclk), .preset(preset_v[2]), .psel(psel_v[2]), .penable(penable_v[2]),
        .pwrite(pwrite_v[2]), .paddr(paddr_v[2]), .pwdata(pwdata_v[2]), .pstrb(pstrb_v[2]),
        .pready(pready_v[2]), .pslverr(pslverr_v[2]), .prdata(prdata_v[2]), .regs_q(regs_v[2])
    );

    typedef struct {
        int          dev;
        logic        rd;
        logic [31:0] rdata;
        logic        err;
        int          setup;
    } exp_t;

    exp_t               sb_q[$];
    logic [7:0][31:0]   mdl [ND];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc    = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] ro_of(input int d);
        return (d == 0) ? 8'h01 : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completing cycle pops the oldest expectation for that device
    always @(negedge pclk) begin
        for (int d = 0; d < ND; d++) begin
            if (pready_v[d] === 1'b1) begin
                int   k;
                exp_t e;
                k = -1;
                foreach (sb_q[i]) if (k < 0 && sb_q[i].dev == d) k = i;
                checks++;
                if (k < 0) begin
                    errors++;
                    $display("FAIL unexpected_pready dev%0d: got pready=1 with no transfer pending", d);
                end else begin
                    e = sb_q[k];
                    sb_q.delete(k);
                    checks++;
                    if (pslverr_v[d] !== e.err) begin
                        errors++;
                        $display("FAIL sb_pslverr dev%0d: got %b expected %b", d, pslverr_v[d], e.err);
                    end
                    if (e.rd) begin
                        checks++;
                        if (prdata_v[d] !== e.rdata) begin
                            errors++;
                            $display("FAIL sb_prdata dev%0d: got %h expected %h", d, prdata_v[d], e.rdata);
                        end
                    end
                    checks++;
                    if (cyc - e.setup != ws_of(d) + 1) begin
                        errors++;
                        $display("FAIL sb_latency dev%0d: got %0d expected %0d", d, cyc - e.setup, ws_of(d) + 1);
                    end
                end
            end else begin
                checks++;
                if (prdata_v[d] !== 32'h0 || pslverr_v[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs dev%0d: got prdata=%h pslverr=%b expected 0/0",
                             d, prdata_v[d], pslverr_v[d]);
                end
            end
        end
    end

    // Reference: a word-indexed array updated by the addressing and strobe rules
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err);
        exp_t       e;
        int         idx;
        logic       valid;
        logic [3:0] se;
        logic [7:0] ro;
        logic       done;
        idx   = int'(addr[7:2]);
        valid = (addr[1:0] == 2'b00) && (idx < 8);
        ro    = ro_of(d);
        e.dev = d; e.rd = !wr; e.setup = cyc; e.rdata = 32'h0; e.err = 1'b0;
        if (!wr) begin
            e.err = !valid;
            if (valid) e.rdata = mdl[d][idx];
        end else begin
            e.err = !valid || ro[idx[2:0]];
`ifdef APB_REGFILE_PSTRB_EN
            se = strb;
`else
            se = 4'hF;
`endif
            if (!e.err)
                for (int b = 0; b < 4; b++)
                    if (se[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
        end
        sb_q.push_back(e);
        psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
        paddr_v[d] = addr; pwdata_v[d] = wdata; pstrb_v[d] = strb;
        @(posedge pclk); #1;
        penable_v[d] = 1'b1;
        done = 1'b0; rdata = 32'h0; err = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge pclk);
            if (pready_v[d] === 1'b1) begin
                done = 1'b1; rdata = prdata_v[d]; err = pslverr_v[d];
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout dev%0d addr %h: got no pready expected pready within 40 cycles", d, addr);
        end
        @(posedge pclk); #1;
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  a;
        int          d;
        preset_v = '1; psel_v = '0; penable_v = '0; pwrite_v = '0;
        paddr_v = '0; pwdata_v = '0; pstrb_v = '0;
        for (int i = 0; i < ND; i++) mdl[i] = '0;
        repeat (3) @(posedge pclk);
        #1 preset_v = '0;

        for (int i = 0; i < ND; i++) begin
            chk("rst_regs", regs_v[i], 256'h0);
            chk("rst_pready", 256'(pready_v[i]), 256'h0);
        end

        // Default-latency write then read-back
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, er);
        chk("ws0_rdata", 256'(rd), 256'(32'hDEADBEEF));
        chk("ws0_err", 256'(er), 256'h0);

        // Three wait states
        xfer(1, 1'b1, 8'h00, 32'hA5A50F0F, 4'hF, rd, er);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, er);
        chk("ws3_rdata", 256'(rd), 256'(32'hA5A50F0F));

        // Byte strobes, including an all-zero strobe
        xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd, er);
        xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, rd, er);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er);
`ifdef APB_REGFILE_PSTRB_EN
        chk("strb_rdata", 256'(rd), 256'(32'h11BB33DD));
`else
        chk("strb_rdata", 256'(rd), 256'(32'hAABBCCDD));
`endif
        xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0000, rd, er);
        chk("strb0_err", 256'(er), 256'h0);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er);
`ifdef APB_REGFILE_PSTRB_EN
        chk("strb0_rdata", 256'(rd), 256'(32'h11BB33DD));
`else
        chk("strb0_rdata", 256'(rd), 256'(32'hFFFFFFFF));
`endif

        // Error responses
        xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, rd, er);
        chk("oor_err", 256'(er), 256'h1);
        chk("oor_rdata", 256'(rd), 256'h0);
        xfer(0, 1'b1, 8'h03, 32'h12345678, 4'hF, rd, er);
        chk("misalign_err", 256'(er), 256'h1);
        xfer(0, 1'b1, 8'h00, 32'hCAFEF00D, 4'hF, rd, er);
        chk("ro_err", 256'(er), 256'h1);
        chk("ro_unchanged", 256'(regs_v[0][31:0]), 256'h0);

        // Abort after one access cycle
        xfer(2, 1'b1, 8'h10, 32'h13572468, 4'hF, rd, er);
        psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1;
        paddr_v[2] = 8'h10; pwdata_v[2] = 32'hFFFF0000; pstrb_v[2] = 4'hF;
        idle(1);
        penable_v[2] = 1'b1;
        idle(1);
        psel_v[2] = 1'b0; penable_v[2] = 1'b0;
        idle(4);
        chk("abort_reg", 256'(regs_v[2][4*32 +: 32]), 256'(32'h13572468));
        xfer(2, 1'b0, 8'h10, 32'h0, 4'h0, rd, er);
        chk("abort_next_rdata", 256'(rd), 256'(32'h13572468));

        // Reset in the middle of a write's wait phase
        xfer(1, 1'b1, 8'h0C, 32'h12345678, 4'hF, rd, er);
        psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
        paddr_v[1] = 8'h0C; pwdata_v[1] = 32'hFFFFFFFF; pstrb_v[1] = 4'hF;
        idle(1);
        penable_v[1] = 1'b1;
        @(posedge pclk); #2;
        preset_v[1] = 1'b1;
        #1;
        chk("rst_mid_pready", 256'(pready_v[1]), 256'h0);
        chk("rst_mid_pslverr", 256'(pslverr_v[1]), 256'h0);
        chk("rst_mid_prdata", 256'(prdata_v[1]), 256'h0);
        chk("rst_mid_regs", regs_v[1], 256'h0);
        mdl[1] = '0;
        psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        @(posedge pclk); #1;
        preset_v[1] = 1'b0;
        idle(2);
        chk("rst_after_regs", regs_v[1], 256'h0);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er);
        chk("rst_after_rdata", 256'(rd), 256'h0);

        // Randomised traffic, mostly back-to-back
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
            else a = 8'($urandom_range(0, 9) * 4);
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er);
            if ($urandom_range(0, 3) == 0) idle(1);
            if (n % 100 == 99)
                for (int i = 0; i < ND; i++) chk("rand_regs", regs_v[i], 256'(mdl[i]));
        end

        idle(3);
        for (int i = 0; i < ND; i++) chk("final_regs", regs_v[i], 256'(mdl[i]));
        chk("sb_empty", 256'(sb_q.size()), 256'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
